// File: rtl/btb_assoc_param.sv
// N-way set-associative BTB with tree PLRU, 2-bit counters and a flush walk.
// Optional: define BTB_DIR_COUNTER_EN for per-entry direction counters.
module btb_assoc_param #(
    parameter int ADDR_W    = 16,
    parameter int WAYS      = 4,
    parameter int SETS_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_valid,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              flush_req,
    output logic              flush_busy
);

    localparam int SETS  = 1 << SETS_LOG2;
    localparam int TAG_W = ADDR_W - SETS_LOG2 - 1;
    localparam int WAY_W = $clog2(WAYS);
    localparam int PL_W  = WAYS - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WALK = 1'b1;

    logic [0:0]           state_q;
    logic [SETS_LOG2-1:0] cnt_q;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [PL_W-1:0]   plru_q  [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [ADDR_W-1:0] tgt_q   [SETS][WAYS];
`ifdef BTB_DIR_COUNTER_EN
    logic [1:0]        ctr_q   [SETS][WAYS];
`endif

    // Each PLRU node bit points toward the victim: 0 = left, 1 = right.
    function automatic logic [WAY_W-1:0] plru_victim(
        input logic [PL_W-1:0] bits
    );
        int node;
        int nxt;
        logic [WAY_W-1:0] v;
        node = 0;
        v    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            nxt = node;
            for (int n = 0; n < PL_W; n++) begin
                if (n == node) nxt = 2 * n + 1 + (bits[n] ? 1 : 0);
            end
            node = nxt;
        end
        for (int w = 0; w < WAYS; w++) begin
            if (node == w + PL_W) v = WAY_W'(w);
        end
        return v;
    endfunction

    function automatic logic [PL_W-1:0] plru_touch(
        input logic [PL_W-1:0]  bits,
        input logic [WAY_W-1:0] way
    );
        int   node;
        logic dir;
        logic [PL_W-1:0] b;
        b    = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = way[WAY_W-1-l];
            for (int n = 0; n < PL_W; n++) begin
                if (n == node) b[n] = ~dir;
            end
            node = 2 * node + 1 + (dir ? 1 : 0);
        end
        return b;
    endfunction

    logic [SETS_LOG2-1:0] lk_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic [SETS_LOG2-1:0] up_idx;
    logic [TAG_W-1:0]     up_tag;

    assign lk_idx = lookup_pc[SETS_LOG2:1];
    assign lk_tag = lookup_pc[ADDR_W-1:SETS_LOG2+1];
    assign up_idx = upd_pc[SETS_LOG2:1];
    assign up_tag = upd_pc[ADDR_W-1:SETS_LOG2+1];

    logic flushing;
    assign flushing   = (state_q == S_WALK) || flush_req;
    assign flush_busy = (state_q == S_WALK);

    logic              lk_hit;
    logic [WAY_W-1:0]  lk_way;
    logic              lk_hit_eff;
    logic              lk_taken;
    logic [ADDR_W-1:0] lk_target;

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        lk_hit_eff = lookup_valid && !flushing && lk_hit;
        lk_target  = lk_hit_eff ? tgt_q[lk_idx][lk_way] : '0;
`ifdef BTB_DIR_COUNTER_EN
        lk_taken   = lk_hit_eff && ctr_q[lk_idx][lk_way][1];
`else
        lk_taken   = lk_hit_eff;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_valid  <= lookup_valid;
            pred_hit    <= lk_hit_eff;
            pred_taken  <= lk_taken;
            pred_target <= lk_target;
        end
    end

    logic             up_hit;
    logic [WAY_W-1:0] up_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;

    always_comb begin
        up_hit    = 1'b0;
        up_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    logic             do_upd;
    logic             hit_wr;
    logic             kill;
    logic             alloc;
    logic             touch;
    logic [WAY_W-1:0] wr_way;
    logic [PL_W-1:0]  plru_nxt;

    always_comb begin
        do_upd = upd_valid && !flushing;
        hit_wr = 1'b0;
        kill   = 1'b0;
        alloc  = 1'b0;
        unique case (1'b1)
            (do_upd && up_hit): begin
`ifdef BTB_DIR_COUNTER_EN
                hit_wr = 1'b1;
`else
                hit_wr = upd_taken;
                kill   = !upd_taken;
`endif
            end
            (do_upd && !up_hit): alloc = upd_taken;
            default: ;
        endcase
        if (up_hit)         wr_way = up_way;
        else if (inv_found) wr_way = inv_way;
        else                wr_way = plru_victim(plru_q[up_idx]);
        touch    = hit_wr || alloc;
        plru_nxt = plru_touch(plru_q[up_idx], wr_way);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (flush_req) begin
                        state_q <= S_WALK;
                        cnt_q   <= '0;
                    end
                end
                S_WALK: begin
                    valid_q[cnt_q] <= '0;
                    plru_q[cnt_q]  <= '0;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == SETS_LOG2'(SETS - 1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (touch) plru_q[up_idx] <= plru_nxt;
            if (alloc) valid_q[up_idx][wr_way] <= 1'b1;
            if (kill)  valid_q[up_idx][wr_way] <= 1'b0;
        end
    end

    // Payload arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (hit_wr || alloc) tgt_q[up_idx][wr_way] <= upd_target;
        if (alloc) tag_q[up_idx][wr_way] <= up_tag;
`ifdef BTB_DIR_COUNTER_EN
        if (alloc) begin
            ctr_q[up_idx][wr_way] <= 2'b10;
        end else if (hit_wr) begin
            if (upd_taken && ctr_q[up_idx][wr_way] != 2'b11)
                ctr_q[up_idx][wr_way] <= ctr_q[up_idx][wr_way] + 2'd1;
            else if (!upd_taken && ctr_q[up_idx][wr_way] != 2'b00)
                ctr_q[up_idx][wr_way] <= ctr_q[up_idx][wr_way] - 2'd1;
        end
`endif
    end

endmodule
